// File: rtl/deserializer_pkg.sv
// -----------------------------------------------------------------------------
// deserializer_pkg
//   Shared helpers for the deserializer family (RTL and benches).
//   len_width : width of a length field able to hold 0..n_samples
//   clamp_len : maps a requested frame length onto the legal range 1..n_samples;
//               0 or anything above n_samples selects a full frame
// -----------------------------------------------------------------------------
package deserializer_pkg;

   localparam int unsigned DefaultNSamples = 8;
   localparam int unsigned DefaultBitWidth = 32;

   function automatic int unsigned len_width(input int unsigned n_samples);
      return $clog2(n_samples + 1);
   endfunction

   function automatic int unsigned clamp_len(input int unsigned cfg,
                                             input int unsigned n_samples);
      if (cfg == 0 || cfg > n_samples) begin
         return n_samples;
      end
      return cfg;
   endfunction

endpackage

// File: rtl/deser_bank.sv
// -----------------------------------------------------------------------------
// deser_bank
//   One frame buffer of the ping-pong deserializer: N_SAMPLES words plus the
//   stored frame length. Words at index >= stored length read as zero.
// Ports
//   clk      in   clock
//   reset    in   synchronous active-high reset (clears words and length)
//   wr_en    in   write recv word at wr_idx
//   wr_idx   in   word index (0..N_SAMPLES-1)
//   wr_data  in   word to store
//   len_en   in   load len_in into the stored length
//   len_in   in   frame length to store
//   rd_msg   out  masked word array
//   rd_len   out  stored length
// -----------------------------------------------------------------------------
module deser_bank
   import deserializer_pkg::*;
#(
   parameter int unsigned N_SAMPLES = DefaultNSamples,
   parameter int unsigned BIT_WIDTH = DefaultBitWidth,
   localparam int unsigned LW       = len_width(N_SAMPLES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [LW-1:0]        wr_idx,
   input  logic [BIT_WIDTH-1:0] wr_data,
   input  logic                 len_en,
   input  logic [LW-1:0]        len_in,
   output logic [BIT_WIDTH-1:0] rd_msg [N_SAMPLES-1:0],
   output logic [LW-1:0]        rd_len
);

   logic [BIT_WIDTH-1:0] mem_q [N_SAMPLES-1:0];
   logic [LW-1:0]        len_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q <= '0;
         for (int i = 0; i < N_SAMPLES; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (len_en) begin
            len_q <= len_in;
         end
         for (int i = 0; i < N_SAMPLES; i++) begin
            if (wr_en && wr_idx == LW'(i)) begin
               mem_q[i] <= wr_data;
            end
         end
      end
   end

   // Masking hides words left over from a longer earlier frame.
   always_comb begin
      for (int i = 0; i < N_SAMPLES; i++) begin
         rd_msg[i] = (LW'(i) < len_q) ? mem_q[i] : '0;
      end
      rd_len = len_q;
   end

endmodule

// File: rtl/deserializer_pingpong.sv
// -----------------------------------------------------------------------------
// deserializer_pingpong
//   Collects a runtime-selectable number of samples from a val/rdy stream into
//   a frame and presents it on a val/rdy output. Two banks alternate so a new
//   frame fills while the previous one waits; 1 sample/cycle, no frame bubble.
// Ports
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   recv_val  in   sample valid
//   recv_rdy  out  sample ready (depends on state only)
//   recv_msg  in   sample
//   cfg_len   in   samples per frame, sampled at the first sample of a frame
//   send_val  out  frame valid
//   send_rdy  in   frame ready
//   send_msg  out  frame words, word i = i-th sample received, zero beyond len
//   send_len  out  length of presented frame
// -----------------------------------------------------------------------------
module deserializer_pingpong
   import deserializer_pkg::*;
#(
   parameter int unsigned N_SAMPLES = DefaultNSamples,
   parameter int unsigned BIT_WIDTH = DefaultBitWidth,
   localparam int unsigned LW       = len_width(N_SAMPLES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 recv_val,
   output logic                 recv_rdy,
   input  logic [BIT_WIDTH-1:0] recv_msg,
   input  logic [LW-1:0]        cfg_len,
   output logic                 send_val,
   input  logic                 send_rdy,
   output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0],
   output logic [LW-1:0]        send_len
);

   logic [LW-1:0] count_q, count_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [1:0]    full_q, full_d;

   logic          recv_fire, send_fire;
   logic [LW-1:0] eff_len, cur_len;
   logic          frame_last;

   logic [BIT_WIDTH-1:0] bank0_msg [N_SAMPLES-1:0];
   logic [BIT_WIDTH-1:0] bank1_msg [N_SAMPLES-1:0];
   logic [1:0][LW-1:0]   bank_len;

   assign recv_rdy  = !full_q[wr_bank_q];
   assign send_val  = full_q[rd_bank_q];
   assign recv_fire = recv_val && recv_rdy;
   assign send_fire = send_val && send_rdy;

   assign eff_len = LW'(clamp_len(32'(cfg_len), N_SAMPLES));
   // The first sample of a frame uses the live clamped length; later samples
   // use the length latched into the bank, so cfg_len changes are ignored.
   assign cur_len    = (count_q == '0) ? eff_len : bank_len[wr_bank_q];
   assign frame_last = (count_q + LW'(1)) == cur_len;

   always_comb begin
      count_d   = count_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;
      if (recv_fire) begin
         if (frame_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            count_d           = '0;
         end else begin
            count_d = count_q + LW'(1);
         end
      end
      // recv can only complete into a non-full bank, so this never hits the
      // same bank as the completion above.
      if (send_fire) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= '0;
      end else begin
         count_q   <= count_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
      end
   end

   deser_bank #(
      .N_SAMPLES (N_SAMPLES),
      .BIT_WIDTH (BIT_WIDTH)
   ) u_bank0 (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (recv_fire && !wr_bank_q),
      .wr_idx  (count_q),
      .wr_data (recv_msg),
      .len_en  (recv_fire && !wr_bank_q && count_q == '0),
      .len_in  (eff_len),
      .rd_msg  (bank0_msg),
      .rd_len  (bank_len[0])
   );

   deser_bank #(
      .N_SAMPLES (N_SAMPLES),
      .BIT_WIDTH (BIT_WIDTH)
   ) u_bank1 (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (recv_fire && wr_bank_q),
      .wr_idx  (count_q),
      .wr_data (recv_msg),
      .len_en  (recv_fire && wr_bank_q && count_q == '0),
      .len_in  (eff_len),
      .rd_msg  (bank1_msg),
      .rd_len  (bank_len[1])
   );

   always_comb begin
      for (int i = 0; i < N_SAMPLES; i++) begin
         send_msg[i] = rd_bank_q ? bank1_msg[i] : bank0_msg[i];
      end
      send_len = bank_len[rd_bank_q];
   end

endmodule

// File: tb/tb_deserializer_pingpong.sv
// -----------------------------------------------------------------------------
// tb_deserializer_pingpong
//   Directed and random stimulus against a frame-level scoreboard. Each cycle
//   the expected recv_rdy/send_val and the presented frame are compared.
// -----------------------------------------------------------------------------
module tb_deserializer_pingpong;

   localparam int N  = 8;
   localparam int W  = 32;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          recv_val;
   logic          recv_rdy;
   logic [W-1:0]  recv_msg;
   logic [LW-1:0] cfg_len;
   logic          send_val;
   logic          send_rdy;
   logic [W-1:0]  send_msg [N-1:0];
   logic [LW-1:0] send_len;

   deserializer_pingpong #(
      .N_SAMPLES (N),
      .BIT_WIDTH (W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .recv_val (recv_val),
      .recv_rdy (recv_rdy),
      .recv_msg (recv_msg),
      .cfg_len  (cfg_len),
      .send_val (send_val),
      .send_rdy (send_rdy),
      .send_msg (send_msg),
      .send_len (send_len)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard: completed frames awaiting presentation.
   logic [N*W-1:0] sb_msg [$];
   int             sb_len [$];
   logic [N*W-1:0] cur_flat;
   int             cur_len;
   int             cur_cnt;
   logic [W-1:0]   data_ctr;

   task automatic check(input string tag, input logic [N*W-1:0] obs,
                        input logic [N*W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*W-1:0] flat_out();
      logic [N*W-1:0] f;
      for (int i = 0; i < N; i++) f[i*W +: W] = send_msg[i];
      return f;
   endfunction

   function automatic int exp_len(input int cfg);
      return (cfg == 0 || cfg > N) ? N : cfg;
   endfunction

   task automatic model_reset();
      sb_msg.delete();
      sb_len.delete();
      cur_flat = '0;
      cur_cnt  = 0;
      cur_len  = 0;
   endtask

   // One clock cycle: drive, compare at negedge, advance the model.
   task automatic tick(input logic rv, input int cfg, input logic sr, output logic fired);
      logic exp_rdy, exp_val, rf, sf;
      recv_val = rv;
      recv_msg = data_ctr;
      cfg_len  = LW'(cfg);
      send_rdy = sr;
      @(negedge clk);
      exp_rdy = (sb_len.size() < 2);
      exp_val = (sb_len.size() > 0);
      check("recv_rdy", {255'b0, recv_rdy}, {255'b0, exp_rdy});
      check("send_val", {255'b0, send_val}, {255'b0, exp_val});
      if (exp_val) begin
         check("send_len", {{(N*W-LW){1'b0}}, send_len}, (N*W)'(sb_len[0]));
         check("send_msg", flat_out(), sb_msg[0]);
      end
      rf = rv && exp_rdy;
      sf = exp_val && sr;
      if (sf) begin
         void'(sb_msg.pop_front());
         void'(sb_len.pop_front());
      end
      if (rf) begin
         if (cur_cnt == 0) begin
            cur_len  = exp_len(cfg);
            cur_flat = '0;
         end
         cur_flat[cur_cnt*W +: W] = data_ctr;
         cur_cnt++;
         data_ctr++;
         if (cur_cnt == cur_len) begin
            sb_msg.push_back(cur_flat);
            sb_len.push_back(cur_len);
            cur_cnt = 0;
         end
      end
      fired = rf;
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n, input int cfg, input logic sr);
      int   got   = 0;
      int   guard = 0;
      logic f;
      while (got < n && guard < 200) begin
         tick(1'b1, cfg, sr, f);
         if (f) got++;
         guard++;
      end
      check("samples_accepted", (N*W)'(got), (N*W)'(n));
   endtask

   task automatic drain();
      int   guard = 0;
      logic f;
      while (sb_len.size() > 0 && guard < 50) begin
         tick(1'b0, 8, 1'b1, f);
         guard++;
      end
      check("drained", (N*W)'(sb_len.size()), '0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      recv_val = 1'b0;
      send_rdy = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      check("rst_send_val", {255'b0, send_val}, '0);
      check("rst_recv_rdy", {255'b0, recv_rdy}, {255'b0, 1'b1});
      check("rst_send_len", {{(N*W-LW){1'b0}}, send_len}, '0);
      check("rst_send_msg", flat_out(), '0);
   endtask

   initial begin
      logic f;
      int   guard;
      int   got;
      reset    = 1'b1;
      recv_val = 1'b0;
      recv_msg = '0;
      cfg_len  = '0;
      send_rdy = 1'b0;
      data_ctr = 1;
      model_reset();
      @(posedge clk);
      do_reset();

      // 1: one full frame, 1..8, sink always ready.
      data_ctr = 1;
      feed(8, 8, 1'b1);
      tick(1'b0, 8, 1'b1, f);
      drain();

      // 2: two frames held with sink stalled, then released.
      data_ctr = 1;
      feed(16, 8, 1'b0);
      tick(1'b1, 8, 1'b0, f);
      tick(1'b1, 8, 1'b0, f);
      check("both_full_no_accept", {255'b0, f}, '0);
      drain();

      // 3: cfg_len=3 at first sample, changed to 5 mid-frame; next frame len 5.
      tick(1'b1, 3, 1'b1, f);
      feed(2, 5, 1'b1);
      feed(5, 5, 1'b1);
      drain();

      // 4: out-of-range lengths clamp to N; length 1 gives a frame per sample.
      feed(8, 0, 1'b1);
      feed(8, 15, 1'b1);
      feed(4, 1, 1'b1);
      drain();

      // 5: random gaps and lengths.
      got   = 0;
      guard = 0;
      while (got < 1000 && guard < 6000) begin
         tick($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
              $urandom_range(0, 2) != 0, f);
         if (f) got++;
         guard++;
      end
      check("random_accepted", (N*W)'(got), (N*W)'(1000));
      guard = 0;
      while (cur_cnt != 0 && guard < 100) begin
         tick(1'b1, 8, 1'b1, f);
         guard++;
      end
      check("random_tail_done", (N*W)'(cur_cnt), '0);
      drain();

      // 6: reset with one bank full and a partial frame in the other.
      feed(11, 8, 1'b0);
      do_reset();
      data_ctr = 100;
      feed(8, 8, 1'b1);
      tick(1'b0, 8, 1'b1, f);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
